frame_raster_sequencer: RTL and testbench
=========================================

Name: frame_raster_sequencer

Overview:
- Raster-order pixel/plane coordinate sequencer for the frame reader output path.
- Sits directly downstream of the per-axis generic counters. It chains plane, x and y counts into one backpressured Avalon-ST-style beat stream.
- Each beat carries coordinates plus sop/eol/eop flags and drives the memory-read address generator and output packetiser.
- Frame geometry is latched at frame start, so register writes mid-frame do not disturb the frame in flight.

Parameters:
- WORD_LENGTH, 12, width of x/y coordinate and geometry ports.
- PLANES_IN_SEQ, 1, colour planes sent in sequence per pixel (1..4).
- PLANE_WORD_LENGTH, 2, width of out_plane (must hold PLANES_IN_SEQ-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request new frame; sampled only in IDLE.
- cfg_width  in  WORD_LENGTH  active pixels per line; 0 treated as 1.
- cfg_height  in  WORD_LENGTH  lines per frame; 0 treated as 1.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts beat.
- out_x  out  WORD_LENGTH  pixel column.
- out_y  out  WORD_LENGTH  line number.
- out_plane  out  PLANE_WORD_LENGTH  colour plane index.
- out_sop  out  1  first beat of frame.
- out_eol  out  1  last beat of a line.
- out_eop  out  1  last beat of frame.
- frame_done  out  1  single-cycle pulse after the eop beat transfers.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - All outputs 0.
  - Latched geometry = 1x1.
  - Reset mid-frame abandons the frame immediately; no frame_done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, out_valid=0.
  - When start=1, latch w_m1 = max(cfg_width,1)-1 and h_m1 = max(cfg_height,1)-1.
  - Clear plane/x/y to 0 and go to RUN.
  - out_valid=1 with out_sop=1 on the next cycle, i.e. 1 cycle start-to-valid latency.
- RUN:
  - out_valid=1 continuously.
  - A transfer occurs on a cycle with out_valid && out_ready.
  - With no transfer, all outputs hold stable; this is mandatory for the handshake.
- Counter chaining on each transfer:
  - plane increments.
  - At PLANES_IN_SEQ-1, plane wraps to 0 and x increments.
  - At x==w_m1, x wraps to 0 and y increments.
  - Counts compare with equality against latched limits; no overflow past the limit is possible.
- Flags are combinational on registered state:
  - out_sop = (plane==0 && x==0 && y==0).
  - out_eol = (plane==PLANES_IN_SEQ-1 && x==w_m1).
  - out_eop = out_eol && y==h_m1.
- Single-beat frame (1x1, PLANES_IN_SEQ=1): sop, eol and eop are all asserted on the same beat.
- eop transfer: go to DONE and drop out_valid next cycle.
- DONE:
  - frame_done=1 for exactly one cycle, busy=1.
  - Next state is IDLE.
  - start during DONE is ignored.
- start while RUN/DONE: ignored, no queueing.
- cfg_width/cfg_height changes while busy: no effect until the next latch.
- Back-to-back frames: minimum gap is 2 cycles from eop transfer to the next sop valid (DONE, IDLE sample, RUN).
- Throughput: one beat per cycle when out_ready is held high.

Optional Feature:
- Macro: FRAME_RASTER_INTERLACE_EN.
- When defined:
  - Adds input port field_sel (1 bit), sampled together with the geometry in IDLE.
  - y starts at field_sel and increments by 2 per line.
  - out_eop asserts on the last line where y+2 > h_m1.
  - If field_sel=1 and h_m1==0, the field has one line at y=1; behaviour is legal but flagged by an assertion in simulation.
  - out_sop uses y==field_sel instead of y==0.
- When undefined: no field_sel port; progressive behaviour exactly as above.

Test Plan:
- Frame 4x2, PLANES=1, out_ready=1, start pulse:
  - valid 1 cycle later; 8 consecutive beats with x=0,1,2,3,0,1,2,3 and y=0,0,0,0,1,1,1,1.
  - sop on beat 0, eol on beats 3 and 7, eop on beat 7.
  - frame_done 1 cycle after beat 7; busy low 2 cycles after beat 7.
- Frame 2x1, PLANES=3:
  - beats (plane,x) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - eol and eop only on beat 5.
- Frame 3x2 with out_ready toggled 1,0,0,1 repeating:
  - outputs hold during ready=0.
  - exactly 6 transfers with correct order; no skipped or duplicated coordinates.
- cfg_width=0, cfg_height=0:
  - single beat (0,0) with sop=eol=eop=1; then frame_done.
- Frame 8x8 mid-frame disturbances:
  - cfg_width changed to 2 at beat 10: stream continues to 64 beats.
  - start re-pulsed at beat 20: ignored.
  - reset asserted at beat 30: next cycle out_valid=0, busy=0, no frame_done.
- With FRAME_RASTER_INTERLACE_EN, 2x5, field_sel=1:
  - y sequence 1,1,3,3; eop on the beat with x=1,y=3.

Source files
------------

// File: rtl/frame_raster_sequencer.sv
// Raster-order plane/x/y beat sequencer with sop/eol/eop flags and a valid/ready handshake.
// Define FRAME_RASTER_INTERLACE_EN to add field_sel and generate a single interlaced field.
`timescale 1ns/1ps
module frame_raster_sequencer #(
  parameter int WORD_LENGTH       = 12,
  parameter int PLANES_IN_SEQ     = 1,
  parameter int PLANE_WORD_LENGTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WORD_LENGTH-1:0]       cfg_width,
  input  logic [WORD_LENGTH-1:0]       cfg_height,
`ifdef FRAME_RASTER_INTERLACE_EN
  input  logic                         field_sel,
`endif
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_LENGTH-1:0]       out_x,
  output logic [WORD_LENGTH-1:0]       out_y,
  output logic [PLANE_WORD_LENGTH-1:0] out_plane,
  output logic                         out_sop,
  output logic                         out_eol,
  output logic                         out_eop,
  output logic                         frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [PLANE_WORD_LENGTH-1:0] PLANE_LAST = PLANE_WORD_LENGTH'(PLANES_IN_SEQ - 1);
  localparam int WL1 = WORD_LENGTH + 1;
`ifdef FRAME_RASTER_INTERLACE_EN
  localparam logic [WORD_LENGTH-1:0] Y_STEP = WORD_LENGTH'(2);
`else
  localparam logic [WORD_LENGTH-1:0] Y_STEP = WORD_LENGTH'(1);
`endif

  state_t                       state_q, state_d;
  logic [WORD_LENGTH-1:0]       w_m1_q, w_m1_d;
  logic [WORD_LENGTH-1:0]       h_m1_q, h_m1_d;
  logic [WORD_LENGTH-1:0]       x_q, x_d;
  logic [WORD_LENGTH-1:0]       y_q, y_d;
  logic [PLANE_WORD_LENGTH-1:0] plane_q, plane_d;
  logic [WORD_LENGTH-1:0]       y_first;
  logic                         run, plane_last, x_last, last_line, eol_raw, eop_raw;

`ifdef FRAME_RASTER_INTERLACE_EN
  logic field_q, field_d;
  assign y_first   = WORD_LENGTH'(field_q);
  // Widened compare so y+2 cannot wrap near the top of the coordinate range.
  assign last_line = (({1'b0, y_q} + WL1'(2)) > {1'b0, h_m1_q});
`else
  assign y_first   = '0;
  assign last_line = (y_q == h_m1_q);
`endif

  assign run        = (state_q == S_RUN);
  assign plane_last = (plane_q == PLANE_LAST);
  assign x_last     = (x_q == w_m1_q);
  assign eol_raw    = plane_last && x_last;
  assign eop_raw    = eol_raw && last_line;

  always_comb begin
    state_d = state_q;
    w_m1_d  = w_m1_q;
    h_m1_d  = h_m1_q;
    x_d     = x_q;
    y_d     = y_q;
    plane_d = plane_q;
`ifdef FRAME_RASTER_INTERLACE_EN
    field_d = field_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_m1_d  = (cfg_width  == '0) ? '0 : cfg_width  - WORD_LENGTH'(1);
          h_m1_d  = (cfg_height == '0) ? '0 : cfg_height - WORD_LENGTH'(1);
          x_d     = '0;
          plane_d = '0;
`ifdef FRAME_RASTER_INTERLACE_EN
          field_d = field_sel;
          y_d     = WORD_LENGTH'(field_sel);
`else
          y_d     = '0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (eop_raw) begin
            state_d = S_DONE;
          end else if (plane_last) begin
            plane_d = '0;
            if (x_last) begin
              x_d = '0;
              y_d = y_q + Y_STEP;
            end else begin
              x_d = x_q + WORD_LENGTH'(1);
            end
          end else begin
            plane_d = plane_q + PLANE_WORD_LENGTH'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      w_m1_q  <= '0;
      h_m1_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      plane_q <= '0;
`ifdef FRAME_RASTER_INTERLACE_EN
      field_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_m1_q  <= w_m1_d;
      h_m1_q  <= h_m1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plane_q <= plane_d;
`ifdef FRAME_RASTER_INTERLACE_EN
      field_q <= field_d;
`endif
    end
  end

  // Coordinates and flags are forced to 0 outside RUN so idle/reset outputs read as 0.
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = run;
  assign frame_done = (state_q == S_DONE);
  assign out_x      = run ? x_q : '0;
  assign out_y      = run ? y_q : '0;
  assign out_plane  = run ? plane_q : '0;
  assign out_sop    = run && (plane_q == '0) && (x_q == '0) && (y_q == y_first);
  assign out_eol    = run && eol_raw;
  assign out_eop    = run && eop_raw;

`ifdef FRAME_RASTER_INTERLACE_EN
  // Odd field of a one-line frame still produces a line at y=1; legal but suspicious.
  a_odd_field_single_line: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_IDLE && start && field_sel) |-> (cfg_height > WORD_LENGTH'(1)))
    else $warning("odd field requested on a single-line frame");
`endif

endmodule

// File: tb/tb_frame_raster_sequencer.sv
// Scoreboard bench for frame_raster_sequencer: a 1-plane and a 3-plane instance, expected beats queued per frame.
`timescale 1ns/1ps
module tb_frame_raster_sequencer;
  localparam int WL = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start1, start3, out_ready, field_sel;
  logic [WL-1:0] cfg_width, cfg_height;

  logic          busy1, valid1, sop1, eol1, eop1, done1;
  logic [WL-1:0] x1, y1;
  logic [1:0]    pl1;
  logic          busy3, valid3, sop3, eol3, eop3, done3;
  logic [WL-1:0] x3, y3;
  logic [1:0]    pl3;

  frame_raster_sequencer #(.WORD_LENGTH(WL), .PLANES_IN_SEQ(1), .PLANE_WORD_LENGTH(2)) u_p1 (
    .clk(clk), .reset(reset), .start(start1), .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef FRAME_RASTER_INTERLACE_EN
    .field_sel(field_sel),
`endif
    .busy(busy1), .out_valid(valid1), .out_ready(out_ready), .out_x(x1), .out_y(y1),
    .out_plane(pl1), .out_sop(sop1), .out_eol(eol1), .out_eop(eop1), .frame_done(done1));

  frame_raster_sequencer #(.WORD_LENGTH(WL), .PLANES_IN_SEQ(3), .PLANE_WORD_LENGTH(2)) u_p3 (
    .clk(clk), .reset(reset), .start(start3), .cfg_width(cfg_width), .cfg_height(cfg_height),
`ifdef FRAME_RASTER_INTERLACE_EN
    .field_sel(field_sel),
`endif
    .busy(busy3), .out_valid(valid3), .out_ready(out_ready), .out_x(x3), .out_y(y3),
    .out_plane(pl3), .out_sop(sop3), .out_eol(eol3), .out_eop(eop3), .frame_done(done3));

  typedef struct packed {
    logic [1:0]    plane;
    logic [WL-1:0] x;
    logic [WL-1:0] y;
    logic          sop;
    logic          eol;
    logic          eop;
  } beat_t;

  beat_t q1[$];
  beat_t q3[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 1-plane instance: pops on every transfer, also checks hold while stalled.
  beat_t held1;
  logic  stall1 = 1'b0;
  always @(negedge clk) begin
    beat_t b, e;
    b = {pl1, x1, y1, sop1, eol1, eop1};
    if (reset) begin
      stall1 = 1'b0;
    end else begin
      if (stall1 && valid1) chk("p1_hold", b, held1);
      if (valid1 && out_ready) begin
        if (q1.size() == 0) chk("p1_unexpected_beat", b, 0);
        else begin
          e = q1.pop_front();
          chk("p1_beat", b, e);
        end
      end
      stall1 = valid1 && !out_ready;
      held1  = b;
    end
  end

  always @(negedge clk) begin
    beat_t b, e;
    b = {pl3, x3, y3, sop3, eol3, eop3};
    if (!reset && valid3 && out_ready) begin
      if (q3.size() == 0) chk("p3_unexpected_beat", b, 0);
      else begin
        e = q3.pop_front();
        chk("p3_beat", b, e);
      end
    end
  end

  // Expected raster: nested line/pixel/plane loops, first beat is sop.
  task automatic push_frame(input int w, input int h, input int planes, input bit fs, input bit to3);
    int ew, eh, y;
    bit last, first;
    beat_t b;
    ew = (w == 0) ? 1 : w;
    eh = (h == 0) ? 1 : h;
    first = 1'b1;
`ifdef FRAME_RASTER_INTERLACE_EN
    y = int'(fs);
`else
    y = 0;
`endif
    while (y < 4096) begin
`ifdef FRAME_RASTER_INTERLACE_EN
      last = (y + 2 > eh - 1);
`else
      last = (y == eh - 1);
`endif
      for (int x = 0; x < ew; x++) begin
        for (int p = 0; p < planes; p++) begin
          b.plane = 2'(p);
          b.x     = WL'(x);
          b.y     = WL'(y);
          b.sop   = first;
          b.eol   = (p == planes - 1) && (x == ew - 1);
          b.eop   = b.eol && last;
          first   = 1'b0;
          if (to3) q3.push_back(b); else q1.push_back(b);
        end
      end
      if (last) break;
`ifdef FRAME_RASTER_INTERLACE_EN
      y += 2;
`else
      y += 1;
`endif
    end
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input bit use3,
                           input bit toggle, input bit disturb, input bit fs);
    int  n, k;
    bit  seen;
    bit  pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_frame(w, h, use3 ? 3 : 1, fs, use3);
    n = use3 ? q3.size() : q1.size();
    cfg_width  = WL'(w);
    cfg_height = WL'(h);
    field_sel  = fs;
    out_ready  = 1'b1;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    chk({tag, "_valid_after_start"}, use3 ? valid3 : valid1, 1);
    chk({tag, "_sop_first"},         use3 ? sop3 : sop1, 1);
    chk({tag, "_busy_run"},          use3 ? busy3 : busy1, 1);
    seen = 1'b0;
    for (k = 1; k <= 4000; k++) begin
      if (disturb && k == 10) cfg_width = WL'(2);
      if (disturb && k == 20) start1 = 1'b1;
      if (disturb && k == 21) start1 = 1'b0;
      out_ready = toggle ? pat[k % 4] : 1'b1;
      @(posedge clk); #1;
      if (use3 ? done3 : done1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (!toggle) chk({tag, "_done_cycle"}, k, n);
    chk({tag, "_all_beats"}, use3 ? q3.size() : q1.size(), 0);
    chk({tag, "_valid_in_done"}, use3 ? valid3 : valid1, 0);
    chk({tag, "_busy_in_done"},  use3 ? busy3 : busy1, 1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_1cy"}, use3 ? done3 : done1, 0);
    chk({tag, "_busy_low"},       use3 ? busy3 : busy1, 0);
    q1.delete();
    q3.delete();
  endtask

  task automatic reset_mid_frame();
    int n;
    push_frame(8, 8, 1, 1'b0, 1'b0);
    n = q1.size();
    cfg_width  = WL'(8);
    cfg_height = WL'(8);
    field_sel  = 1'b0;
    out_ready  = 1'b1;
    start1     = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", valid1, 0);
    chk("rst_mid_busy",  busy1, 0);
    chk("rst_mid_done",  done1, 0);
    chk("rst_mid_x",     x1, 0);
    chk("rst_mid_left",  q1.size(), n - 30);
    q1.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_no_done", done1, 0);
    chk("rst_mid_idle",    busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    start1     = 1'b0;
    start3     = 1'b0;
    out_ready  = 1'b0;
    field_sel  = 1'b0;
    cfg_width  = '0;
    cfg_height = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", valid1, 0);
    chk("reset_busy",  busy1, 0);
    chk("reset_flags", {sop1, eol1, eop1, done1}, 0);
    chk("reset_coord", {pl1, x1, y1}, 0);
    chk("reset_p3",    {busy3, valid3, sop3, eol3, eop3, done3}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", valid1, 0);
    chk("idle_busy",  busy1, 0);

    run_frame("f4x2",     4, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("f4x2_b2b", 4, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("f2x1p3",   2, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("f3x2tog",  3, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame("f0x0",     0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("f8x8dist", 8, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_mid_frame();
`ifdef FRAME_RASTER_INTERLACE_EN
    run_frame("il2x5",    2, 5, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
